// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared constants and FSM state type for the operand fetch sequencer
//   DATA_W_DEF / SIZE_DEF / CNT_W_DEF : default operand width, RAM depth, pair-count width
//   AW_DEF                            : address width derived from SIZE_DEF
//   state_t                           : sequencer FSM states
package opfetch_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SIZE_DEF   = 4096;
    localparam int CNT_W_DEF  = 12;
    localparam int AW_DEF     = $clog2(SIZE_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        WAIT_A = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4,
        ISSUE  = 3'd5,
        FIN    = 3'd6
    } state_t;

endpackage

// File: rtl/opfetch_out_reg.sv
// opfetch_out_reg: valid/ready holding register for one {sel, b, a} word
//   clk, rst_n : clock, asynchronous active-low reset
//   load, d    : capture d and raise valid
//   ready      : downstream accept; valid clears the cycle after valid & ready
//   valid, q   : held word, stable while valid & !ready
module opfetch_out_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: fetches a/b operand pairs from a word-addressed RAM and issues them
//   clk, rst_n                     : clock, asynchronous active-low reset
//   start, base_addr, num_pairs    : job launch (accepted in IDLE only)
//   busy, done                     : job in progress / one-cycle end-of-job pulse
//   mem_rd_en, mem_addr            : single-cycle read request
//   mem_rd_data, mem_rd_valid      : read return, any latency >= 1
//   a, b, sel, out_valid, out_ready: issued pair, sel marks the last pair of the job
module operand_fetch_seq
    import opfetch_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  SIZE   = SIZE_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    localparam int AW     = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [CNT_W-1:0]  num_pairs,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              sel,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t              state;
    logic [AW-1:0]       ptr;
    logic [CNT_W-1:0]    remaining;
    logic [DATA_W-1:0]   a_hold;
    logic [2*DATA_W:0]   q;
    logic                load;
    logic                hs;
    logic                last;

    assign hs        = out_valid && out_ready;
    assign last      = remaining == CNT_W'(1);
    // The b return completes the pair, so it loads the output register directly
    assign load      = (state == WAIT_B) && mem_rd_valid;
    assign busy      = state != IDLE;
    assign done      = state == FIN;
    assign mem_rd_en = (state == REQ_A) || (state == REQ_B);
    assign mem_addr  = ptr;
    assign {sel, b, a} = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            a_hold    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr       <= base_addr;
                    remaining <= num_pairs;
                    state     <= (num_pairs == '0) ? FIN : REQ_A;
                end
                REQ_A: begin
                    ptr   <= ptr + 1'b1;
                    state <= WAIT_A;
                end
                WAIT_A: if (mem_rd_valid) begin
                    a_hold <= mem_rd_data;
                    state  <= REQ_B;
                end
                REQ_B: begin
                    ptr   <= ptr + 1'b1;
                    state <= WAIT_B;
                end
                WAIT_B: if (mem_rd_valid) state <= ISSUE;
                ISSUE: if (hs) begin
                    remaining <= remaining - 1'b1;
                    state     <= last ? FIN : REQ_A;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    opfetch_out_reg #(.W(2*DATA_W+1)) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .d     ({last, mem_rd_data, a_hold}),
        .ready (out_ready),
        .valid (out_valid),
        .q     (q)
    );

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: directed jobs against a RAM/latency model and a job-level expectation queue
module tb_operand_fetch_seq;
    import opfetch_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int SZ = SIZE_DEF;
    localparam int AW = AW_DEF;
    localparam int CW = CNT_W_DEF;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1, mem_rd_valid = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_pairs = '0;
    logic [DW-1:0] mem_rd_data = '0;
    logic          busy, done, mem_rd_en, sel, out_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] a, b;

    int n_tests = 0, n_fail = 0, cyc = 0, lat = 1;
    logic [DW-1:0]   ram [SZ];
    int              exp_addr[$];
    logic [2*DW:0]   exp_pair[$];
    int              addr_log[$];
    logic [2*DW:0]   pair_log[$];
    bit              job_active = 0;
    int              job_num = 0, start_cyc = 0, last_hs_cyc = 0;
    int              pend = 0;
    logic [AW-1:0]   pend_addr = '0;
    logic [2*DW:0]   prev_q = '0;
    bit              prev_stall = 0, prev_done = 0;

    operand_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_pairs(num_pairs),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // RAM with fixed latency per request; a return may outlive a reset and arrive while idle
    always @(negedge clk) begin
        mem_rd_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = ram[pend_addr];
            end
        end
        if (rst_n && mem_rd_en) begin
            chk("one_outstanding", pend, 0);
            pend      = lat;
            pend_addr = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (mem_rd_en) begin
                addr_log.push_back(int'(mem_addr));
                if (exp_addr.size() == 0) bad("unexpected_read");
                else chk("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", {sel, b, a}, prev_q);
            end
            if (out_valid && out_ready) begin
                pair_log.push_back({sel, b, a});
                last_hs_cyc = cyc;
                if (exp_pair.size() == 0) bad("unexpected_pair");
                else chk("pair", {sel, b, a}, exp_pair.pop_front());
            end
            if (prev_done) begin
                chk("done_width", done, 0);
                chk("busy_after_done", busy, 0);
            end
            if (done) begin
                chk("busy_in_done", busy, 1);
                if (!job_active) bad("unexpected_done");
                else begin
                    chk("done_time", cyc, job_num > 0 ? last_hs_cyc + 1 : start_cyc + 1);
                    chk("pairs_left", exp_pair.size(), 0);
                    chk("addrs_left", exp_addr.size(), 0);
                    job_active = 0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = {sel, b, a};
            prev_done  = done;
        end
    end

    task automatic run_job(input logic [AW-1:0] base, input int num);
        for (int i = 0; i < 2 * num; i++) exp_addr.push_back((int'(base) + i) % SZ);
        for (int i = 0; i < num; i++)
            exp_pair.push_back({i == num - 1, ram[(int'(base) + 2 * i + 1) % SZ], ram[(int'(base) + 2 * i) % SZ]});
        job_active = 1;
        job_num    = num;
        start_cyc  = cyc;
        base_addr  = base;
        num_pairs  = CW'(num);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && job_active; i++) step();
        if (job_active) begin
            bad("done_timeout");
            job_active = 0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rd_en"}, mem_rd_en, 0);
        chk({name, "_addr"}, mem_addr, 0);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_sel_b_a"}, {sel, b, a}, 0);
    endtask

    initial begin
        for (int i = 0; i < SZ; i++) ram[i] = DW'(i) ^ 16'h5A5A;
        step(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);

        // 1: three pairs, latency 1, always ready
        for (int i = 0; i < 6; i++) ram[16 + i] = DW'(i + 1);
        addr_log.delete(); pair_log.delete();
        run_job(12'h010, 3);
        wait_done();
        chk("t1_npairs", pair_log.size(), 3);
        chk("t1_pair0", pair_log[0], {1'b0, 16'd2, 16'd1});
        chk("t1_pair1", pair_log[1], {1'b0, 16'd4, 16'd3});
        chk("t1_pair2", pair_log[2], {1'b1, 16'd6, 16'd5});
        chk("t1_addr_first", addr_log[0], 12'h010);
        chk("t1_addr_last", addr_log[5], 12'h015);
        step(2);

        // 2: empty job
        addr_log.delete(); pair_log.delete();
        run_job(12'h020, 0);
        wait_done();
        chk("t2_reads", addr_log.size(), 0);
        chk("t2_pairs", pair_log.size(), 0);
        chk("t2_hold_a", a, 16'd5);
        step(2);

        // 3: address wrap at top of RAM
        ram[12'hFFF] = 16'hA001; ram[0] = 16'hA002; ram[1] = 16'hA003; ram[2] = 16'hA004;
        addr_log.delete(); pair_log.delete();
        run_job(12'hFFF, 2);
        wait_done();
        chk("t3_nreads", addr_log.size(), 4);
        chk("t3_addr0", addr_log[0], 12'hFFF);
        chk("t3_addr1", addr_log[1], 12'h000);
        chk("t3_addr2", addr_log[2], 12'h001);
        chk("t3_addr3", addr_log[3], 12'h002);
        chk("t3_pair0", pair_log[0], {1'b0, 16'hA002, 16'hA001});
        chk("t3_pair1", pair_log[1], {1'b1, 16'hA004, 16'hA003});
        step(2);

        // 4: backpressure for 10 cycles on extreme signed values
        ram[12'h200] = 16'h8000; ram[12'h201] = 16'h7FFF;
        addr_log.delete(); pair_log.delete();
        out_ready = 1'b0;
        run_job(12'h200, 1);
        for (int i = 0; i < 100 && !out_valid; i++) step();
        chk("t4_valid", out_valid, 1);
        chk("t4_a", a, 16'h8000);
        chk("t4_b", b, 16'h7FFF);
        chk("t4_sel", sel, 1);
        step(10);
        chk("t4_no_hs_yet", pair_log.size(), 0);
        out_ready = 1'b1;
        wait_done();
        chk("t4_one_hs", pair_log.size(), 1);
        step(2);

        // 5: slow RAM and a second start mid-job
        lat = 7;
        for (int i = 0; i < 4; i++) ram[12'h300 + i] = DW'(16'h1100 + i);
        addr_log.delete(); pair_log.delete();
        run_job(12'h300, 2);
        step(3);
        base_addr = '0; num_pairs = CW'(5); start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        chk("t5_npairs", pair_log.size(), 2);
        chk("t5_pair1", pair_log[1], {1'b1, 16'h1103, 16'h1102});
        step(20);
        chk("t5_idle", busy, 0);
        chk("t5_nreads", addr_log.size(), 4);

        // 6: reset while waiting for b, late return afterwards
        lat = 6;
        ram[12'h400] = 16'hBEEF; ram[12'h401] = 16'hCAFE;
        addr_log.delete(); pair_log.delete();
        run_job(12'h400, 1);
        for (int i = 0; i < 100 && addr_log.size() < 2; i++) step();
        chk("t6_b_requested", addr_log.size(), 2);
        step();
        rst_n = 1'b0;
        exp_addr.delete(); exp_pair.delete();
        job_active = 0;
        #1;
        check_reset_outputs("t6_reset");
        step(2);
        rst_n = 1'b1;
        step(8);
        chk("t6_late_busy", busy, 0);
        chk("t6_late_valid", out_valid, 0);
        chk("t6_late_rd", addr_log.size(), 2);
        lat = 1;
        pair_log.delete();
        run_job(12'h400, 1);
        wait_done();
        chk("t6_clean_pair", pair_log[0], {1'b1, 16'hCAFE, 16'hBEEF});
        chk("t6_clean_n", pair_log.size(), 1);

        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
